// File: rtl/fifo_ctrl_16x8.sv
// fifo_ctrl_16x8: pointer/count controller driving an external 16x8 dual-port RAM
// Ports: clk, rst (async active-low); push/push_data, pop request side;
// ram_cs/ram_wr_enb/ram_wr_addr/ram_wr_data/ram_rd_enb/ram_rd_addr RAM side;
// rd_valid marks the cycle RAM rd_data holds the popped word;
// full/empty/count status; overflow/underflow one-cycle reject pulses.
module fifo_ctrl_16x8 #(
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic                  ram_cs,
    output logic                  ram_wr_enb,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic                  ram_rd_enb,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);
    logic [ADDR_WIDTH-1:0] wptr, rptr;
    logic [ADDR_WIDTH:0]   count_nxt;
    logic                  push_ok, pop_ok;
    // a same-cycle push never makes an empty FIFO poppable; a pop frees room for a push when full
    always_comb begin
        pop_ok    = pop & ~empty;
        push_ok   = push & (~full | pop_ok);
        count_nxt = count + (ADDR_WIDTH+1)'(push_ok) - (ADDR_WIDTH+1)'(pop_ok);
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
            full        <= 1'b0;
            empty       <= 1'b1;
            ram_cs      <= 1'b0;
            ram_wr_enb  <= 1'b0;
            ram_rd_enb  <= 1'b0;
            rd_valid    <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            ram_wr_addr <= '0;
            ram_rd_addr <= '0;
            ram_wr_data <= '0;
        end else begin
            count      <= count_nxt;
            full       <= count_nxt == (ADDR_WIDTH+1)'(DEPTH);
            empty      <= count_nxt == '0;
            ram_cs     <= push_ok | pop_ok;
            ram_wr_enb <= push_ok;
            ram_rd_enb <= pop_ok;
            rd_valid   <= pop_ok;
            overflow   <= push & ~push_ok;
            underflow  <= pop & ~pop_ok;
            if (push_ok) begin
                ram_wr_addr <= wptr;
                ram_wr_data <= push_data;
                wptr        <= wptr + ADDR_WIDTH'(1);
            end
            if (pop_ok) begin
                ram_rd_addr <= rptr;
                rptr        <= rptr + ADDR_WIDTH'(1);
            end
        end
    end
endmodule

// File: tb/tb_fifo_ctrl_16x8.sv
// tb_fifo_ctrl_16x8: directed self-checking bench with a behavioural 16x8 RAM
module tb_fifo_ctrl_16x8;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       push = 1'b0, pop = 1'b0;
    logic [7:0] push_data = '0;
    logic       ram_cs, ram_wr_enb, ram_rd_enb, rd_valid, full, empty, overflow, underflow;
    logic [3:0] ram_wr_addr, ram_rd_addr;
    logic [7:0] ram_wr_data, rd_data;
    logic [4:0] count;
    logic [7:0] mem [16];
    logic [7:0] q [$];
    int         checks = 0, errors = 0;
    int         wp, rp;

    always #5 clk = ~clk;

    fifo_ctrl_16x8 dut (
        .clk(clk), .rst(rst), .push(push), .push_data(push_data), .pop(pop),
        .ram_cs(ram_cs), .ram_wr_enb(ram_wr_enb), .ram_wr_addr(ram_wr_addr),
        .ram_wr_data(ram_wr_data), .ram_rd_enb(ram_rd_enb), .ram_rd_addr(ram_rd_addr),
        .rd_valid(rd_valid), .full(full), .empty(empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always @(posedge clk) if (ram_wr_enb) mem[ram_wr_addr] <= ram_wr_data;
    assign rd_data = mem[ram_rd_addr];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic cyc(input logic p, input logic [7:0] d, input logic r);
        push = p;
        push_data = d;
        pop = r;
        @(posedge clk);
        #1;
        push = 1'b0;
        pop = 1'b0;
    endtask

    task automatic check_idle_reset(input string tag);
        check({tag, "_flags"}, {ram_cs, ram_wr_enb, ram_rd_enb, rd_valid, full, empty, overflow, underflow}, 8'b0000_0100);
        check({tag, "_bus"}, {ram_wr_addr, ram_rd_addr, ram_wr_data}, 16'h0000);
        check({tag, "_count"}, count, 0);
    endtask

    task automatic do_reset;
        rst = 1'b0;
        #1;
        check_idle_reset("rst");
        @(posedge clk);
        #1;
        rst = 1'b1;
        q.delete();
        wp = 0;
        rp = 0;
    endtask

    task automatic push_one(input logic [7:0] d);
        cyc(1'b1, d, 1'b0);
        check("push_wr", {ram_wr_enb, ram_wr_addr, ram_wr_data}, {1'b1, 4'(wp), d});
        q.push_back(d);
        wp++;
    endtask

    task automatic pop_one;
        logic [7:0] e;
        e = q.pop_front();
        cyc(1'b0, 8'h00, 1'b1);
        check("pop_rd", {rd_valid, ram_rd_enb, ram_rd_addr, rd_data}, {2'b11, 4'(rp), e});
        rp++;
    endtask

    initial begin
        #12;
        check_idle_reset("por");
        @(posedge clk);
        #1;
        rst = 1'b1;
        wp = 0;
        rp = 0;
        // first push lands at address 0
        cyc(1'b1, 8'hA5, 1'b0);
        check("p1_wr", {ram_cs, ram_wr_enb, ram_wr_addr, ram_wr_data}, {2'b11, 4'h0, 8'hA5});
        check("p1_status", {count, empty, full}, {5'd1, 2'b00});
        cyc(1'b0, 8'h00, 1'b0);
        check("p1_hold", {ram_cs, ram_wr_enb, ram_wr_addr, ram_wr_data}, {2'b00, 4'h0, 8'hA5});
        cyc(1'b0, 8'h00, 1'b1);
        check("p1_pop", {rd_valid, ram_rd_addr, rd_data, count, empty}, {1'b1, 4'h0, 8'hA5, 5'd0, 1'b1});
        // fill 16 then drain 16
        do_reset();
        for (int i = 0; i < 16; i++) push_one(8'(i));
        check("fill_status", {count, full, empty}, {5'd16, 2'b10});
        for (int i = 0; i < 16; i++) pop_one();
        check("drain_status", {count, full, empty}, {5'd0, 2'b01});
        // full: rejected push, then push+pop together
        for (int i = 0; i < 16; i++) push_one(8'h10 + 8'(i));
        cyc(1'b1, 8'h77, 1'b0);
        check("ovf", {overflow, ram_wr_enb, ram_cs, count, full}, {3'b100, 5'd16, 1'b1});
        cyc(1'b0, 8'h00, 1'b0);
        check("ovf_end", {overflow, count}, {1'b0, 5'd16});
        cyc(1'b1, 8'h88, 1'b1);
        check("full_pair", {ram_wr_enb, ram_wr_addr, ram_wr_data, ram_rd_enb, ram_rd_addr, rd_data},
              {1'b1, 4'h0, 8'h88, 1'b1, 4'h0, 8'h10});
        check("full_pair_status", {count, full, overflow}, {5'd16, 2'b10});
        void'(q.pop_front());
        q.push_back(8'h88);
        wp++;
        rp++;
        for (int i = 0; i < 16; i++) pop_one();
        check("drain2_status", {count, empty}, {5'd0, 1'b1});
        // empty: rejected pop, then push+pop where only the push is taken
        cyc(1'b0, 8'h00, 1'b1);
        check("unf", {underflow, rd_valid, ram_rd_enb, ram_cs, count}, {4'b1000, 5'd0});
        cyc(1'b1, 8'h42, 1'b1);
        check("unf_pair", {underflow, rd_valid, ram_wr_enb, ram_wr_addr, ram_wr_data, count},
              {3'b101, 4'(wp), 8'h42, 5'd1});
        q.push_back(8'h42);
        wp++;
        pop_one();
        // wrap: 10 entries resident, 20 simultaneous push/pop pairs
        for (int i = 0; i < 10; i++) push_one(8'h30 + 8'(i));
        for (int i = 0; i < 20; i++) begin
            logic [7:0] e;
            e = q.pop_front();
            cyc(1'b1, 8'h40 + 8'(i), 1'b1);
            check("wrap_wr", {ram_wr_enb, ram_wr_addr, ram_wr_data}, {1'b1, 4'(wp), 8'h40 + 8'(i)});
            check("wrap_rd", {rd_valid, ram_rd_addr, rd_data, count}, {1'b1, 4'(rp), e, 5'd10});
            q.push_back(8'h40 + 8'(i));
            wp++;
            rp++;
        end
        for (int i = 0; i < 10; i++) pop_one();
        check("wrap_status", {count, empty}, {5'd0, 1'b1});
        // asynchronous reset mid-stream with 5 entries
        for (int i = 0; i < 5; i++) push_one(8'h60 + 8'(i));
        check("pre_rst_count", count, 5);
        push = 1'b1;
        push_data = 8'h55;
        #2;
        rst = 1'b0;
        #1;
        check_idle_reset("async");
        @(posedge clk);
        #1;
        check_idle_reset("held");
        push = 1'b0;
        rst = 1'b1;
        q.delete();
        wp = 0;
        rp = 0;
        push_one(8'h99);
        check("post_rst_count", {count, empty}, {5'd1, 1'b0});
        pop_one();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
